// File: rtl/fcs_check_if.sv
`default_nettype none
// ============================================================================
// Module      : fcs_check_if
// Description : Dibit stream bundle for the receive-side FCS checker.
//               The master side drives frame dibits in and observes the
//               stripped body plus the per-frame check result.
// Revision    : 1.0 - initial release
// ============================================================================
interface fcs_check_if;
  logic       axiiv;
  logic [1:0] axiid;
  logic       axiov;
  logic [1:0] axiod;
  logic       done;
  logic       kill;

  modport master (
    output axiiv,
    output axiid,
    input  axiov,
    input  axiod,
    input  done,
    input  kill
  );

  modport slave (
    input  axiiv,
    input  axiid,
    output axiov,
    output axiod,
    output done,
    output kill
  );
endinterface
`default_nettype wire

// File: rtl/fcs_check.sv
`default_nettype none
// ============================================================================
// Module      : fcs_check
// Description : Strips the trailing 32-bit FCS from a dibit frame, forwards
//               the body downstream and recomputes CRC32-BZIP2 over it.
//               At end of frame a done pulse reports pass (kill=0) or
//               fail (kill=1).
// Revision    : 1.0 - initial release
// ============================================================================
module fcs_check (
  input  wire           clk,
  input  wire           rst,
  fcs_check_if.slave    bus
);

  localparam logic [31:0] c_POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] c_CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] c_CRC_XOR  = 32'hFFFF_FFFF;
  localparam logic [4:0]  c_FULL     = 5'd16;

  logic        r_prev_axiiv;
  logic [4:0]  r_fill;
  logic [31:0] r_sr;
  logic        r_body_seen;
  logic [31:0] r_crc;
  logic        r_axiov;
  logic [1:0]  r_axiod;
  logic        r_done;
  logic        r_kill;

  logic        w_full;
  logic        w_eof;
  logic [31:0] w_crc_next;
  logic        w_bad;

  // Two serial MSB-first CRC steps, bit 1 of the dibit first.
  function automatic logic [31:0] f_crc_dibit(input logic [31:0] crc,
                                              input logic [1:0]  d);
    logic [31:0] t;
    logic        fb;
    t = crc;
    for (int k = 1; k >= 0; k--) begin
      fb = t[31] ^ d[k];
      t  = {t[30:0], 1'b0} ^ (fb ? c_POLY : 32'h0);
    end
    return t;
  endfunction

  // The delay line only releases a dibit once it holds a full FCS worth.
  assign w_full     = (r_fill == c_FULL);
  assign w_eof      = r_prev_axiiv & ~bus.axiiv;
  assign w_crc_next = f_crc_dibit(r_crc, r_sr[31:30]);
  // The delay line holds the received FCS with its MSB dibit oldest, so it
  // compares directly against the finalised CRC.
  assign w_bad      = ~w_full | ~r_body_seen | ((r_crc ^ c_CRC_XOR) != r_sr);

  // Delay line, CRC accumulation, body forwarding and end-of-frame verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_axiiv <= 1'b0;
      r_fill       <= 5'd0;
      r_sr         <= 32'h0;
      r_body_seen  <= 1'b0;
      r_crc        <= c_CRC_INIT;
      r_axiov      <= 1'b0;
      r_axiod      <= 2'b00;
      r_done       <= 1'b0;
      r_kill       <= 1'b0;
    end else begin
      r_prev_axiiv <= bus.axiiv;
      r_axiov      <= 1'b0;
      r_done       <= 1'b0;
      if (bus.axiiv) begin
        r_sr   <= {r_sr[29:0], bus.axiid};
        r_fill <= w_full ? c_FULL : r_fill + 5'd1;
        if (w_full) begin
          r_axiov     <= 1'b1;
          r_axiod     <= r_sr[31:30];
          r_crc       <= w_crc_next;
          r_body_seen <= 1'b1;
        end
      end else if (w_eof) begin
        r_done      <= 1'b1;
        r_kill      <= w_bad;
        r_crc       <= c_CRC_INIT;
        r_fill      <= 5'd0;
        r_body_seen <= 1'b0;
      end
    end
  end

  assign bus.axiov = r_axiov;
  assign bus.axiod = r_axiod;
  assign bus.done  = r_done;
  assign bus.kill  = r_kill;

endmodule
`default_nettype wire

// File: doc/fcs_check.md
# fcs_check

Receive-side counterpart of the Ethernet packager's FCS generator. Accepts a frame as a stream of dibits (MSB-first within each byte) ending with its 32-bit FCS, and strips the FCS. It forwards the body dibits downstream and recomputes CRC32-BZIP2 over the body. At end of frame it reports pass/fail, so the receive path can drop corrupted frames.

## Interface
- No parameters.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- axiiv  in  1  input dibit valid; stays high for the whole frame; a falling edge marks end of frame.
- axiid  in  2  input dibit; bit 1 is transmitted first.
- axiov  out  1  body dibit valid (FCS dibits never appear here).
- axiod  out  2  body dibit, same bit order as input.
- done  out  1  one-cycle pulse when a frame's check completes.
- kill  out  1  check result, valid when done=1 and held until the next done or reset: 1 = bad FCS or malformed frame, 0 = good.

## Operation
- **Delay line:** 16-entry dibit shift register (32 bits) plus a fill counter (0..16, saturating at 16).
- **On each cycle with axiiv=1:**
  - The new dibit shifts in and fill increments.
  - If fill was already 16, the oldest dibit is popped.
- **Each popped dibit is a body dibit:**
  - It is driven on axiod with axiov=1.
  - It is folded into the CRC register.
  - It sets a body_seen flag.
- **CRC:**
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, final XOR 0xFFFFFFFF.
  - Per dibit d, run two serial steps, d[1] then d[0]: fb = crc[31]^bit; crc = {crc[30:0],0} ^ (fb ? 0x04C11DB7 : 0).
- **End of frame:** the cycle where prev_axiiv=1 and axiiv=0.
  - The delay line then holds the received FCS; its oldest dibit is FCS[31:30] and its newest is FCS[1:0].
  - kill = (fill≠16) | ~body_seen | ((crc ^ 0xFFFFFFFF) ≠ FCS).
  - done pulses.
  - The CRC reloads 0xFFFFFFFF, and fill and body_seen clear.
- **Gaps:** any deassertion of axiiv ends the frame. Frames have no mid-frame gaps; a gap splits the stream into two frames, each checked separately.
- **Rising edge of axiiv:** no special action. State is already clean from the previous end-of-frame or reset.
- **Reset:**
  - Outputs: axiov=0, axiod=0, done=0, kill=0.
  - Internal: prev_axiiv=0, fill=0, body_seen=0, crc=0xFFFFFFFF, shift register=0.
- **Reset mid-frame:** the frame is abandoned and no done is produced for it. Input arriving after rst deasserts starts a fresh frame.

## Timing
- All outputs are registered.
- Let input dibit i (0-based within the frame) be accepted at edge t_i. For i≥16, body dibit i−16 appears on axiod with axiov=1 in the cycle after t_i.
- Latency: 16 accepted dibits plus 1 clock. axiov is low in every cycle after an edge with no pop.
- A frame of N total dibits (N≥17) gives exactly N−16 axiov cycles, contiguous when the input was contiguous.
- If the end-of-frame condition holds at edge E:
  - done=1 and kill are valid in cycle E+1.
  - axiov=0 in cycle E+1.
  - done=0 in cycle E+2.
- Minimum inter-frame gap is one axiiv=0 cycle. A new frame may start in the cycle right after the end-of-frame cycle; its first dibit sees crc=0xFFFFFFFF and fill=0.
- The CRC update and the pop of a dibit occur on the same edge. The compare at E uses the CRC including the last body dibit, popped at E−1.
- rst has priority over all other activity at any edge.

## Test plan
- **Good frame:** body is ASCII "123456789" (0x31..0x39, 36 dibits, each byte MSB-first), followed by FCS 0xFC891918 (16 dibits).
  - Expect 36 contiguous axiov cycles reproducing the body exactly, starting 17 cycles after the first input dibit.
  - Then done=1, kill=0 one cycle after axiiv falls.
- **Corrupt body:** same frame with one body bit flipped (e.g. first byte 0x30) → body forwarded, done=1, kill=1.
- **Corrupt FCS:** same body with FCS 0xFC891919 → done=1, kill=1. Repeat with only FCS[31] flipped to check compare alignment → kill=1.
- **Malformed frames:**
  - 10-dibit frame: no axiov cycles, done=1, kill=1.
  - Exactly 16 dibits of 0x00000000: no axiov cycles, done=1, kill=1 (empty body).
- **Back-to-back frames:** good frame, one idle cycle, corrupt frame, one idle cycle, good frame → three done pulses with kill = 0, 1, 0, and no body dibits leaking between frames.
- **Reset mid-frame:** assert rst for one cycle after 20 dibits of a frame.
  - Outputs go to 0 and no done is produced.
  - The good "123456789" frame sent afterwards yields kill=0.
